daw_menu_controller: RTL

//  Navigation sequencer for the DAW main screen. Debounces the four push-buttons,

---
 rtl/daw_menu_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/daw_menu_controller.sv
// daw_menu_controller: debounces the four push-buttons into single-cycle press
// events and runs the main-screen menu FSM (row highlight and page open/close).
module daw_menu_controller #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int NUM_ROWS     = 4,
    parameter int WRAP         = 1
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [1:0] sel_row,
    output logic [2:0] page_id,
    output logic       in_page,
    output logic       open_pulse,
    output logic       close_pulse,
    output logic [3:0] key_evt
);

    localparam int              CW       = $clog2(DEBOUNCE_CYC + 2);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   DB_LAST  = CW'(DEBOUNCE_CYC - 1);
    // A key must be seen released for DEBOUNCE_CYC+2 cycles after reset before
    // it is armed; the extra two cycles cover the synchronizer's reset contents.
    localparam logic [CW-1:0]   ARM_LAST = CW'(DEBOUNCE_CYC + 1);
    localparam logic [1:0]      ROW_LAST = 2'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_PAGE  = 2'd2,
        ST_CLOSE = 2'd3
    } state_t;

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    db_q, db_d;
    logic [3:0]    arm_q, arm_d;
    logic [3:0]    evt_q, evt_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    state_t        state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [2:0]    page_q, page_d;
    logic          in_page_q, in_page_d;
    logic          open_q, open_d;
    logic          close_q, close_d;
    logic [3:0]    evt_use_s;
    logic          unused_sw_s;

    assign unused_sw_s = ^SW[9:1];
    // Navigation lock hides events from the FSM but not from key_evt.
    assign evt_use_s   = SW[0] ? 4'b0000 : evt_q;

    // Debouncer next state: arming after reset, level acceptance, press events.
    always_comb begin
        db_d  = db_q;
        arm_d = arm_q;
        evt_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!arm_q[i]) begin
                if (sync2_q[i]) begin
                    if (cnt_q[i] == ARM_LAST) begin
                        arm_d[i] = 1'b1;
                        cnt_d[i] = CNT_ZERO;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end else begin
                    cnt_d[i] = CNT_ZERO;
                end
            end else if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == DB_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = CNT_ZERO;
                evt_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Input path registers: synchronizer, debounce state and event register.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            db_q    <= 4'hF;
            arm_q   <= 4'h0;
            evt_q   <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            arm_q   <= arm_d;
            evt_q   <= evt_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Menu FSM next state; outputs are computed here so they register with the state.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        page_d    = page_q;
        in_page_d = in_page_q;
        open_d    = 1'b0;
        close_d   = 1'b0;
        case (state_q)
            ST_MENU: begin
                if (evt_use_s[3]) begin
                    state_d = ST_MENU;
                end else if (evt_use_s[2]) begin
                    state_d   = ST_OPEN;
                    page_d    = {1'b0, row_q} + 3'd1;
                    in_page_d = 1'b1;
                    open_d    = 1'b1;
                end else if (evt_use_s[0] && !evt_use_s[1]) begin
                    if (row_q == ROW_LAST) begin
                        row_d = (WRAP != 0) ? 2'd0 : ROW_LAST;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else if (evt_use_s[1] && !evt_use_s[0]) begin
                    if (row_q == 2'd0) begin
                        row_d = (WRAP != 0) ? ROW_LAST : 2'd0;
                    end else begin
                        row_d = row_q - 2'd1;
                    end
                end else begin
                    row_d = row_q;
                end
            end
            ST_OPEN: begin
                state_d = ST_PAGE;
            end
            ST_PAGE: begin
                if (evt_use_s[3]) begin
                    state_d   = ST_CLOSE;
                    page_d    = 3'd0;
                    in_page_d = 1'b0;
                    close_d   = 1'b1;
                end else begin
                    state_d = ST_PAGE;
                end
            end
            ST_CLOSE: begin
                state_d = ST_MENU;
            end
            default: begin
                state_d   = ST_MENU;
                page_d    = 3'd0;
                in_page_d = 1'b0;
            end
        endcase
    end

    // Menu FSM state and registered outputs.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_MENU;
            row_q     <= 2'd0;
            page_q    <= 3'd0;
            in_page_q <= 1'b0;
            open_q    <= 1'b0;
            close_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            page_q    <= page_d;
            in_page_q <= in_page_d;
            open_q    <= open_d;
            close_q   <= close_d;
        end
    end

    assign sel_row     = row_q;
    assign page_id     = page_q;
    assign in_page     = in_page_q;
    assign open_pulse  = open_q;
    assign close_pulse = close_q;
    assign key_evt     = evt_q;

endmodule
